alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_iter.sv | 121 ++++++++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states, iterative-unit modes.
// Build macro ALU_SEQ_DIV_EN enables the DIVU/REMU datapath.
package alu_seq_pkg;

  localparam int ALU_SEQ_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SLL  = 4'd6,
    OP_ROTR = 4'd7,
    OP_MOV  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_DIVU = 2'd1,
    MODE_REMU = 2'd2
  } iter_mode_e;

endpackage

// File: rtl/alu_seq_iter.sv
// One-bit-per-cycle datapath shared by shift-add multiply and restoring divide.
// Divide support is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             active,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;
  logic [CNTW-1:0]  cnt_r;
  iter_mode_e       mode_r;
  logic [WIDTH-1:0] hi_nx_s;
  logic [WIDTH-1:0] lo_nx_s;
  logic [WIDTH:0]   sum_s;
`ifdef ALU_SEQ_DIV_EN
  logic             dz_r;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
`endif

  assign last = active && (cnt_r == CNTW'(WIDTH - 1));

  // Next value of {hi,lo} for one iteration of the selected algorithm.
  always_comb begin
    sum_s   = {(WIDTH+1){1'b0}};
    hi_nx_s = hi_r;
    lo_nx_s = lo_r;
`ifdef ALU_SEQ_DIV_EN
    rem_sh_s = {hi_r, lo_r[WIDTH-1]};
    diff_s   = rem_sh_s[WIDTH-1:0] - opnd_r;
`endif
    case (mode_r)
      MODE_MUL: begin
        // hi accumulates the partial product; lo shifts multiplier bits out as product bits shift in
        if (lo_r[0]) begin
          sum_s = {1'b0, hi_r} + {1'b0, opnd_r};
        end else begin
          sum_s = {1'b0, hi_r};
        end
        hi_nx_s = sum_s[WIDTH:1];
        lo_nx_s = {sum_s[0], lo_r[WIDTH-1:1]};
      end
`ifdef ALU_SEQ_DIV_EN
      MODE_DIVU, MODE_REMU: begin
        if (rem_sh_s >= {1'b0, opnd_r}) begin
          hi_nx_s = diff_s;
          lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_nx_s = rem_sh_s[WIDTH-1:0];
          lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
        end
      end
`endif
      default: begin
        hi_nx_s = hi_r;
        lo_nx_s = lo_r;
      end
    endcase
  end

  // Result taken from the post-iteration value so the top can load it on the last cycle.
  always_comb begin
    result   = lo_nx_s;
    overflow = |hi_nx_s;
`ifdef ALU_SEQ_DIV_EN
    if (mode_r == MODE_REMU) begin
      result = hi_nx_s;
    end else begin
      result = lo_nx_s;
    end
    if (mode_r == MODE_MUL) begin
      overflow = |hi_nx_s;
    end else begin
      overflow = dz_r;
    end
`endif
  end

  // Operand load on start, one iteration per active cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      cnt_r  <= {CNTW{1'b0}};
      mode_r <= MODE_MUL;
`ifdef ALU_SEQ_DIV_EN
      dz_r   <= 1'b0;
`endif
    end else if (start) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= src_a;
      opnd_r <= src_b;
      cnt_r  <= {CNTW{1'b0}};
      mode_r <= mode;
`ifdef ALU_SEQ_DIV_EN
      dz_r   <= (src_b == {WIDTH{1'b0}});
`endif
    end else if (active) begin
      hi_r  <= hi_nx_s;
      lo_r  <= lo_nx_s;
      cnt_r <= cnt_r + CNTW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops computed here, MUL (and DIVU/REMU when
// ALU_SEQ_DIV_EN is defined) handed to alu_seq_iter; one registered output slot.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam logic [SHW:0] WIDTH_V = (SHW+1)'(WIDTH);

  state_e           state_r;
  logic             accept_s;
  logic             start_s;
  logic             is_multi_s;
  iter_mode_e       mode_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   amt_s;
  logic [SHW:0]     inv_amt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             iter_last_s;
  logic [WIDTH-1:0] iter_res_s;
  logic             iter_ovf_s;

  assign in_ready  = !reset && (state_r == ST_IDLE) && (!out_valid || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign start_s   = accept_s && is_multi_s;
  assign busy      = (state_r == ST_ITER);
  assign sum_s     = src1 + src2;
  assign diff_s    = src1 - src2;
  assign amt_s     = src2[SHW-1:0];
  assign inv_amt_s = WIDTH_V - {1'b0, amt_s};

  // Single-cycle result and signed-overflow flag.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum_s[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff_s[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_AND:  alu_res_s = src1 & src2;
      OP_OR:   alu_res_s = src1 | src2;
      OP_XOR:  alu_res_s = src1 ^ src2;
      OP_SRL:  alu_res_s = src1 >> amt_s;
      OP_SLL:  alu_res_s = src1 << amt_s;
      // amount 0 gives a WIDTH-bit left shift, which contributes nothing
      OP_ROTR: alu_res_s = (src1 >> amt_s) | (src1 << inv_amt_s);
      OP_MOV:  alu_res_s = src1;
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Decode which ops run on the iterative unit.
  always_comb begin
    is_multi_s = 1'b0;
    mode_s     = MODE_MUL;
    case (op_e'(op))
      OP_MUL: begin
        is_multi_s = 1'b1;
        mode_s     = MODE_MUL;
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: begin
        is_multi_s = 1'b1;
        mode_s     = MODE_DIVU;
      end
      OP_REMU: begin
        is_multi_s = 1'b1;
        mode_s     = MODE_REMU;
      end
`endif
      default: begin
        is_multi_s = 1'b0;
        mode_s     = MODE_MUL;
      end
    endcase
  end

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (start_s),
    .active   (busy),
    .mode     (mode_s),
    .src_a    (src1),
    .src_b    (src2),
    .last     (iter_last_s),
    .result   (iter_res_s),
    .overflow (iter_ovf_s)
  );

  // Control FSM and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_ITER;
            out_valid <= 1'b0;
          end else if (accept_s) begin
            out_valid <= 1'b1;
            result    <= alu_res_s;
            overflow  <= alu_ovf_s;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_ITER: begin
          if (iter_last_s) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= iter_res_s;
            overflow  <= iter_ovf_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=32); honours ALU_SEQ_DIV_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Reference model: returns {result, overflow}.
  function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [63:0] p;
    longint      s;
    r = 32'd0;
    v = 1'b0;
    case (o)
      4'd0: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; v = (s != longint'($signed(r))); end
      4'd1: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; v = (s != longint'($signed(r))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a >> b[4:0];
      4'd6: r = a << b[4:0];
      4'd7: begin
        r = a;
        for (int k = 0; k < int'(b[4:0]); k++) r = {r[0], r[31:1]};
      end
      4'd8: r = a;
      4'd9: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; v = |p[63:32]; end
`ifdef ALU_SEQ_DIV_EN
      4'd10: begin if (b == 32'd0) begin r = 32'hFFFF_FFFF; v = 1'b1; end else r = a / b; end
      4'd11: begin if (b == 32'd0) begin r = a; v = 1'b1; end else r = a % b; end
`endif
      default: begin r = 32'd0; v = 1'b0; end
    endcase
    return {r, v};
  endfunction

  function automatic int lat_of(input logic [3:0] o);
`ifdef ALU_SEQ_DIV_EN
    if (o == 4'd9 || o == 4'd10 || o == 4'd11) return 33;
`else
    if (o == 4'd9) return 33;
`endif
    return 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its result, compare against the scoreboard and latency.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int n;
    in_valid  = 1'b1;
    op        = o;
    src1      = a;
    src2      = b;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("in_ready_at_issue", in_ready, 1);
    sb_q.push_back(model(o, a, b));
    tick();
    in_valid = 1'b0;
    op       = 4'd3;
    src1     = $urandom;
    src2     = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      check("busy_and_not_ready_in_iter", {busy, in_ready}, 2'b10);
      tick();
      n++;
    end
    check("latency", n, lat_of(o));
    check("out_valid", out_valid, 1);
    exp = sb_q.pop_front();
    check("result", result, exp[32:1]);
    check("overflow", overflow, exp[0]);
    tick();
    check("drained", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp;
    logic        seen;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op        = 4'd0;
    src1      = 32'd0;
    src2      = 32'd0;
    #1;
    check("in_ready_during_reset", in_ready, 0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'd1, 32'h0000_0000, 32'h0000_0001);
    run_op(4'd1, 32'h8000_0000, 32'h0000_0001);
    run_op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000);
    run_op(4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
    run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFE4);
    run_op(4'd6, 32'h0000_0001, 32'h0000_001F);
    run_op(4'd7, 32'h0000_0001, 32'hFFFF_FF21);
    run_op(4'd7, 32'h1234_5678, 32'h0000_0020);
    run_op(4'd8, 32'hDEAD_BEEF, 32'h1111_1111);
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'd9, 32'h0001_0000, 32'h0001_0000);
    run_op(4'd9, 32'd1234, 32'd5678);
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'd10, 32'd100, 32'd7);
    run_op(4'd11, 32'd100, 32'd7);
    run_op(4'd10, 32'd5, 32'd0);
    run_op(4'd11, 32'd5, 32'd0);

    // Back-pressure: SUB result held while a new request waits.
    in_valid  = 1'b1;
    op        = 4'd1;
    src1      = 32'd3;
    src2      = 32'd5;
    out_ready = 1'b0;
    check("bp_in_ready_issue", in_ready, 1);
    sb_q.push_back(model(4'd1, 32'd3, 32'd5));
    tick();
    op   = 4'd0;
    src1 = 32'd1;
    src2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 32'hFFFF_FFFE);
      check("bp_overflow", overflow, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_drain_ready", in_ready, 1);
    exp = sb_q.pop_front();
    check("bp_drain_result", result, exp[32:1]);
    sb_q.push_back(model(4'd0, 32'd1, 32'd1));
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    exp = sb_q.pop_front();
    check("bp_next_result", result, exp[32:1]);
    check("bp_next_overflow", overflow, exp[0]);
    tick();
    check("bp_next_drained", out_valid, 0);

    // Reset in the middle of a MUL aborts it.
    in_valid  = 1'b1;
    op        = 4'd9;
    src1      = 32'h0001_0000;
    src2      = 32'h0001_0000;
    out_ready = 1'b1;
    check("abort_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_stale_result", seen, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
